// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential signed multiply/divide unit for the execute stage.
//
// Computes MUL / MULH with a one-bit-per-cycle shift-add multiplier and
// DIV / REM with a one-bit-per-cycle non-restoring divider, both working
// on operand magnitudes. The sign is applied once at the end.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   start       request pulse, accepted in IDLE or DONE
//   op          00 MUL, 01 MULH, 10 DIV, 11 REM
//   operand_a   signed multiplicand / dividend
//   operand_b   signed multiplier / divisor
//   flush       synchronous abort, wins over start
//   busy        high in PREP, RUN and FIN
//   result_rdy  one-cycle pulse while result/exception are fresh
//   result      registered result, held until the next FIN
//   exception   registered error flag, qualified by result_rdy
//
// Optional build macro: MULDIV_EARLY_EXIT_EN
//   When defined, PREP jumps straight to FIN if either operand is zero,
//   skipping the iteration phase. Results are identical either way.

module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Two's-complement negation helpers.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1'b1);
  endfunction

  function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v);
    return ~v + W2'(1'b1);
  endfunction

  // Magnitude as unsigned; MIN_INT maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg_w(v) : v;
  endfunction

  state_t             state_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  // Partial product high half (MUL) or signed partial remainder (DIV).
  // Two extra bits keep the remainder sign exact when the divisor is 2^(WIDTH-1).
  logic [WIDTH+1:0]   acc_r;
  // Multiplier / product low half (MUL) or dividend / quotient (DIV).
  logic [WIDTH-1:0]   shift_r;
  logic [WIDTH-1:0]   mag_b_r;
  logic               neg_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               rdy_r;
  logic [WIDTH-1:0]   result_r;
  logic               exc_r;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH+1:0]   div_shl_s;
  logic [WIDTH+1:0]   div_dext_s;
  logic [WIDTH+1:0]   div_new_s;
  logic [W2-1:0]      prod_s;
  logic [WIDTH-1:0]   rem_mag_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic               b_zero_s;
  logic               min_neg1_s;
  logic [WIDTH-1:0]   fin_result_s;
  logic               fin_exc_s;

  assign b_zero_s   = (b_r == {WIDTH{1'b0}});
  assign min_neg1_s = (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == {WIDTH{1'b1}});

`ifdef MULDIV_EARLY_EXIT_EN
  // A zero operand makes every op trivial: product 0, or quotient/remainder 0,
  // or the divide-by-zero override applied in FIN.
  logic early_s;
  assign early_s = (a_r == {WIDTH{1'b0}}) || (b_r == {WIDTH{1'b0}});
`endif

  // One iteration of the shift-add multiplier and of the non-restoring divider.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[WIDTH-1:0]}
               + (shift_r[0] ? {1'b0, mag_b_r} : {(WIDTH+1){1'b0}});
    div_shl_s  = {acc_r[WIDTH:0], shift_r[WIDTH-1]};
    div_dext_s = {2'b00, mag_b_r};
    if (acc_r[WIDTH+1]) begin
      div_new_s = div_shl_s + div_dext_s;
    end else begin
      div_new_s = div_shl_s - div_dext_s;
    end
  end

  // Final sign application and output selection evaluated during FIN.
  always_comb begin
    prod_s = neg_r ? neg_w2({acc_r[WIDTH-1:0], shift_r}) : {acc_r[WIDTH-1:0], shift_r};
    // A negative final remainder gets the one deferred restore step.
    if (acc_r[WIDTH+1]) begin
      rem_mag_s = acc_r[WIDTH-1:0] + mag_b_r;
    end else begin
      rem_mag_s = acc_r[WIDTH-1:0];
    end
    quot_s       = neg_r ? neg_w(shift_r) : shift_r;
    rem_s        = neg_r ? neg_w(rem_mag_s) : rem_mag_s;
    fin_result_s = {WIDTH{1'b0}};
    fin_exc_s    = 1'b0;
    case (op_r)
      2'b00: begin
        fin_result_s = prod_s[WIDTH-1:0];
        // Overflow unless the top WIDTH+1 bits are all equal.
        fin_exc_s    = ~((&prod_s[W2-1:WIDTH-1]) | ~(|prod_s[W2-1:WIDTH-1]));
      end
      2'b01: begin
        fin_result_s = prod_s[W2-1:WIDTH];
        fin_exc_s    = 1'b0;
      end
      2'b10: begin
        if (b_zero_s) begin
          fin_result_s = {WIDTH{1'b0}};
          fin_exc_s    = 1'b1;
        end else begin
          // MIN_INT / -1 already yields MIN_INT from the magnitude path.
          fin_result_s = quot_s;
          fin_exc_s    = min_neg1_s;
        end
      end
      2'b11: begin
        if (b_zero_s) begin
          fin_result_s = {WIDTH{1'b0}};
          fin_exc_s    = 1'b1;
        end else begin
          fin_result_s = rem_s;
          fin_exc_s    = 1'b0;
        end
      end
      default: begin
        fin_result_s = {WIDTH{1'b0}};
        fin_exc_s    = 1'b0;
      end
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      op_r     <= 2'b00;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      acc_r    <= {(WIDTH+2){1'b0}};
      shift_r  <= {WIDTH{1'b0}};
      mag_b_r  <= {WIDTH{1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      rdy_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      exc_r    <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      if (flush) begin
        state_r <= S_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE, S_DONE: begin
            if (start) begin
              op_r    <= op;
              a_r     <= operand_a;
              b_r     <= operand_b;
              state_r <= S_PREP;
              busy_r  <= 1'b1;
            end else begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end
          S_PREP: begin
            acc_r   <= {(WIDTH+2){1'b0}};
            shift_r <= abs_w(a_r);
            mag_b_r <= abs_w(b_r);
            cnt_r   <= {CNT_W{1'b0}};
            // REM follows the dividend sign; the rest follow sign(a) xor sign(b).
            neg_r   <= (op_r == 2'b11) ? a_r[WIDTH-1] : (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
`ifdef MULDIV_EARLY_EXIT_EN
            if (early_s) begin
              shift_r <= {WIDTH{1'b0}};
              state_r <= S_FIN;
            end else begin
              state_r <= S_RUN;
            end
`else
            state_r <= S_RUN;
`endif
          end
          S_RUN: begin
            if (op_r[1]) begin
              acc_r   <= div_new_s;
              shift_r <= {shift_r[WIDTH-2:0], ~div_new_s[WIDTH+1]};
            end else begin
              acc_r   <= {1'b0, 1'b0, mul_sum_s[WIDTH:1]};
              shift_r <= {mul_sum_s[0], shift_r[WIDTH-1:1]};
            end
            cnt_r <= cnt_r + CNT_W'(1'b1);
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
              state_r <= S_FIN;
            end else begin
              state_r <= S_RUN;
            end
          end
          S_FIN: begin
            result_r <= fin_result_s;
            exc_r    <= fin_exc_s;
            rdy_r    <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= S_DONE;
          end
          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = busy_r;
  assign result_rdy = rdy_r;
  assign result     = result_r;
  assign exception  = exc_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq (WIDTH=32). The stimulus process pushes
// hand-computed results into queues; a monitor pops and compares on every
// result_rdy pulse, including the latency measured from the start edge.

module tb_muldiv_seq;

  localparam int WIDTH    = 32;
  // PREP + WIDTH RUN iterations + FIN: result_rdy follows edge k+WIDTH+2.
  localparam int LAT_FULL = WIDTH + 2;
`ifdef MULDIV_EARLY_EXIT_EN
  // PREP then FIN: result_rdy follows edge k+2.
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_ZERO = WIDTH + 2;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] operand_a = 32'h0;
  logic [WIDTH-1:0] operand_b = 32'h0;
  logic             busy;
  logic             result_rdy;
  logic [WIDTH-1:0] result;
  logic             exception;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_res_q[$];
  logic        exp_exc_q[$];
  int          exp_at_q[$];
  int          exp_lat_q[$];
  int          exp_id_q[$];

  // Directed vectors: op, a, b, expected result, expected exception, latency.
  logic [1:0]  v_op  [0:13] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10,
                                2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b10};
  logic [31:0] v_a   [0:13] = '{32'h00010000, 32'h00010000, 32'h00000007, 32'hFFFFFFFF,
                                32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'd0, 32'd0};
  logic [31:0] v_b   [0:13] = '{32'h00010000, 32'h00010000, 32'hFFFFFFFA, 32'h80000000,
                                32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd3, 32'hFFFFFFFD, 32'd0, 32'd0, 32'd5, 32'd5};
  logic [31:0] v_res [0:13] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000,
                                32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                                32'h00000021, 32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        v_exc [0:13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  int          v_lat [0:13] = '{LAT_FULL, LAT_FULL, LAT_FULL, LAT_FULL, LAT_FULL, LAT_FULL,
                                LAT_FULL, LAT_FULL, LAT_FULL, LAT_FULL,
                                LAT_ZERO, LAT_ZERO, LAT_ZERO, LAT_ZERO};

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flush      (flush),
    .busy       (busy),
    .result_rdy (result_rdy),
    .result     (result),
    .exception  (exception)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s op#%0d actual=0x%0h required=0x%0h", nm, id, act, req);
    end
  endtask

  // Drive one start pulse (held for exactly one rising edge).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] er, input logic ee,
                       input int lat, input int id);
    @(negedge clock);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    if (push) begin
      exp_res_q.push_back(er);
      exp_exc_q.push_back(ee);
      exp_at_q.push_back(cyc + 1);
      exp_lat_q.push_back(lat);
      exp_id_q.push_back(id);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int id);
    int n = 0;
    while (exp_res_q.size() != 0 && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (exp_res_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout op#%0d actual=no_result_rdy required=result_rdy", id);
      exp_res_q.delete();
      exp_exc_q.delete();
      exp_at_q.delete();
      exp_lat_q.delete();
      exp_id_q.delete();
    end
  endtask

  // Monitor: every result_rdy pulse must match the oldest expectation.
  always @(negedge clock) begin : monitor
    int id;
    if (reset && result_rdy) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy actual=pulse(result=0x%0h) required=no_pulse", result);
      end else begin
        id = exp_id_q.pop_front();
        check("result", id, result, exp_res_q.pop_front());
        check("exception", id, {31'b0, exception}, {31'b0, exp_exc_q.pop_front()});
        check("latency", id, 32'(cyc - exp_at_q.pop_front()), 32'(exp_lat_q.pop_front()));
      end
    end
  end

  initial begin : stim
    int bc;
    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_busy", 0, {31'b0, busy}, 32'h0);
    check("rst_rdy", 0, {31'b0, result_rdy}, 32'h0);
    check("rst_result", 0, result, 32'h0);
    check("rst_exc", 0, {31'b0, exception}, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // MUL 7 * -6, and busy length across PREP, RUN and FIN.
    issue(2'b00, 32'd7, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFD6, 1'b0, LAT_FULL, 1);
    bc = busy ? 1 : 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (busy) bc++;
      if (result_rdy) break;
    end
    check("busy_cycles", 1, 32'(bc), 32'(WIDTH + 2));
    wait_drain(1);

    for (int i = 0; i < 14; i++) begin
      issue(v_op[i], v_a[i], v_b[i], 1'b1, v_res[i], v_exc[i], v_lat[i], i + 2);
      wait_drain(i + 2);
    end

    // Start while busy with different operands must be ignored.
    issue(2'b10, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, LAT_FULL, 30);
    repeat (5) @(negedge clock);
    issue(2'b00, 32'd9, 32'd9, 1'b0, 32'h0, 1'b0, 0, 31);
    wait_drain(30);

    // Flush mid-operation: no pulse, busy drops, result held.
    issue(2'b10, 32'd100, 32'd3, 1'b0, 32'h0, 1'b0, 0, 40);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", 40, {31'b0, busy}, 32'h0);
    check("flush_result_held", 40, result, 32'd14);
    check("flush_exc_held", 40, {31'b0, exception}, 32'h0);
    repeat (40) @(negedge clock);
    issue(2'b00, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, LAT_FULL, 41);
    wait_drain(41);

    // Reset asserted mid-RUN clears outputs immediately.
    issue(2'b00, 32'd5, 32'd6, 1'b0, 32'h0, 1'b0, 0, 50);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 50, {31'b0, busy}, 32'h0);
    check("midrst_rdy", 50, {31'b0, result_rdy}, 32'h0);
    check("midrst_result", 50, result, 32'h0);
    check("midrst_exc", 50, {31'b0, exception}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_busy", 50, {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog actual=still_running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
